ioblock_bank: RTL
=================

# ioblock_bank

Parametrised bank of WIDTH bidirectional FPGA I/O pins sharing one I/O clock. Each pin has its own tristate mode, an optional input register and an optional output/enable register. Per-pin configuration is loaded through a serial configuration chain with a bit counter and an atomic commit. The bank sits at the device boundary between the pad ring and the routing fabric. It replaces single-pin I/O blocks whose configuration is fixed at elaboration.

## Interface
- WIDTH, 8, number of pins in the bank (≥1)
- CHAIN_LEN, 4*WIDTH, configuration chain length (derived; not overridable)

- IOCLK  input  1  I/O clock; all state changes on the rising edge
- RSTN  input  1  asynchronous active-low reset
- PIN  inout  WIDTH  pad pins
- TS  input  WIDTH  per-pin tristate control from fabric
- OUT  input  WIDTH  per-pin output data from fabric
- IN  output  WIDTH  per-pin input data to fabric
- CE  input  1  clock enable for the pin data registers (D, Q, OE_Q)
- CFG_EN  input  1  shift enable for the configuration chain
- CFG_DIN  input  1  serial configuration data in
- CFG_DOUT  output  1  serial configuration data out; equals chain[CHAIN_LEN-1]
- CFG_LOAD  input  1  request to commit the chain into the active configuration
- CFG_ERR  output  1  last CFG_LOAD was rejected

## Operation
- Shift: when CFG_EN=1, chain <= {chain[CHAIN_LEN-2:0], CFG_DIN}. Counter cnt increments and saturates at CHAIN_LEN.
- Field layout for pin i:
  - chain[4i+1:4i] = TSMUX
  - chain[4i+2] = DORREG
  - chain[4i+3] = OUTREG
  - The first bit shifted in therefore lands at pin WIDTH-1 OUTREG.
- Commit: CFG_LOAD=1 is evaluated with pre-edge chain and cnt values.
  - If cnt==CHAIN_LEN: active config <= chain, CFG_ERR <= 0.
  - Otherwise: active config is unchanged, CFG_ERR <= 1.
  - In both cases cnt <= (CFG_EN ? 1 : 0).
- CFG_EN and CFG_LOAD together: the commit uses the pre-shift chain, and the shift still takes effect.
- Drive enable oe_i by TSMUX:
  - 00: never drive
  - 01: drive when TS[i]=1
  - 10: always drive
  - 11: drive when TS[i]=0
- OUTREG=0: PIN[i] = oe_i ? OUT[i] : 'z (combinational).
- OUTREG=1: Q[i] <= OUT[i] and OE_Q[i] <= oe_i when CE=1; PIN[i] = OE_Q[i] ? Q[i] : 'z.
- Input register: D[i] <= PIN[i] when CE=1. Capture happens every cycle regardless of drive state, so readback of driven values is supported.
- IN[i] = DORREG ? D[i] : PIN[i].
- A 'z pin with DORREG=0 propagates 'z/'x to IN. No pull is modelled.
- Reset values:
  - chain=0, cnt=0
  - active config=0, i.e. all pins hi-Z with direct input
  - D=Q=OE_Q=0
  - CFG_ERR=0, CFG_DOUT=0
  - PIN all 'z; IN follows PIN.
- Reset mid-shift discards the partial chain. Reset asserted asynchronously releases all pins to hi-Z immediately.

## Timing
- Direct paths (OUTREG=0, DORREG=0): zero-cycle combinational, OUT/TS → PIN and PIN → IN.
- Registered output: PIN reflects OUT/TS sampled at the previous CE edge (1-cycle latency).
- Registered input: IN reflects PIN sampled at the previous CE edge (1-cycle latency).
- The new configuration takes effect immediately after the committing edge. Q/OE_Q/D are not cleared on commit.
- CFG_DOUT is valid 1 cycle after each shift edge, which allows banks to be daisy-chained.
- CFG_ERR updates on the CFG_LOAD edge and holds until the next CFG_LOAD or reset.
- CE=0 freezes D, Q and OE_Q. The config chain and counter do not depend on CE.

## Structure
- Package ioblock_pkg holds:
  - TSMUX encodings: TS_OFF=2'b00, TS_HIGH=2'b01, TS_ON=2'b10, TS_LOW=2'b11
  - CFG_BITS_PER_PIN=4
  - field offsets: TSMUX_LSB=0, DORREG_BIT=2, OUTREG_BIT=3
- Sub-module ioblock_cell: one-pin datapath (oe decode, Q/OE_Q/D registers, tristate driver, IN mux), instantiated WIDTH times via generate.
- ioblock_bank owns the chain, counter, active config and CFG_ERR.

## Test plan
- WIDTH=4. Reset → PIN=4'bzzzz, CFG_ERR=0, IN follows externally driven PIN=4'b1010 combinationally.
- Shift 16 bits configuring every pin TSMUX=01, DORREG=0, OUTREG=0, then CFG_LOAD. Drive OUT=4'b1111, TS=4'b0101 → PIN=4'bz1z1 in the same cycle.
- Shift only 15 bits, then CFG_LOAD → CFG_ERR=1 and the configuration is unchanged. A full 16-bit shift and load → CFG_ERR=0.
- Pin 0 with OUTREG=1, TSMUX=10. OUT[0] 0→1 → PIN[0] changes 1 cycle later. With CE=0, PIN[0] holds its value.
- Pin 1 with TSMUX=11, DORREG=1. TS[1]=0, OUT[1]=1 → PIN[1]=1 and IN[1]=1 one cycle later. TS[1]=1 with external 0 → IN[1]=0 one cycle later.
- Assert RSTN low mid-shift (8 bits in) → PIN all 'z immediately. After release, CFG_LOAD → CFG_ERR=1 (cnt=0).

Source files
------------

// File: rtl/ioblock_pkg.sv
// Shared types and constants for the I/O bank: tristate mux encodings and the
// per-pin configuration field layout used by the serial chain.
package ioblock_pkg;

  typedef enum logic [1:0] {
    TS_OFF  = 2'b00,
    TS_HIGH = 2'b01,
    TS_ON   = 2'b10,
    TS_LOW  = 2'b11
  } tsmux_e;

  localparam int CFG_BITS_PER_PIN = 4;
  localparam int TSMUX_LSB        = 0;
  localparam int DORREG_BIT       = 2;
  localparam int OUTREG_BIT       = 3;

  typedef struct packed {
    logic   outreg;
    logic   dorreg;
    tsmux_e tsmux;
  } pin_cfg_t;

  function automatic logic decode_oe(input tsmux_e mode, input logic ts);
    logic oe;
    case (mode)
      TS_OFF:  oe = 1'b0;
      TS_HIGH: oe = ts;
      TS_ON:   oe = 1'b1;
      TS_LOW:  oe = ~ts;
      default: oe = 1'b0;
    endcase
    return oe;
  endfunction

endpackage

// File: rtl/ioblock_cell.sv
// One-pin datapath: drive-enable decode, optional output/enable and input
// registers, the pad tristate driver and the input select toward the fabric.
module ioblock_cell
  import ioblock_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     ce,
  input  pin_cfg_t cfg,
  input  logic     fab_ts,
  input  logic     fab_out,
  output logic     fab_in,
  inout  wire      pin
);

  logic oe;
  logic q_q, q_d;
  logic oe_q, oe_d;
  logic d_q, d_d;
  logic drv_en;
  logic drv_val;

  always_comb begin
    oe   = decode_oe(cfg.tsmux, fab_ts);
    q_d  = q_q;
    oe_d = oe_q;
    d_d  = d_q;
    if (ce) begin
      q_d  = fab_out;
      oe_d = oe;
      d_d  = pin;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q  <= 1'b0;
      oe_q <= 1'b0;
      d_q  <= 1'b0;
    end else begin
      q_q  <= q_d;
      oe_q <= oe_d;
      d_q  <= d_d;
    end
  end

  // The input register samples the pad even while we drive it, so readback works.
  assign drv_en  = cfg.outreg ? oe_q : oe;
  assign drv_val = cfg.outreg ? q_q  : fab_out;
  assign pin     = drv_en ? drv_val : 1'bz;
  assign fab_in  = cfg.dorreg ? d_q : pin;

endmodule

// File: rtl/ioblock_bank.sv
// Bank of WIDTH configurable I/O pins with a serial configuration chain,
// saturating bit counter and all-or-nothing commit of the active configuration.
module ioblock_bank
  import ioblock_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             IOCLK,
  input  logic             RSTN,
  inout  wire  [WIDTH-1:0] PIN,
  input  logic [WIDTH-1:0] TS,
  input  logic [WIDTH-1:0] OUT,
  output logic [WIDTH-1:0] IN,
  input  logic             CE,
  input  logic             CFG_EN,
  input  logic             CFG_DIN,
  output logic             CFG_DOUT,
  input  logic             CFG_LOAD,
  output logic             CFG_ERR
);

  localparam int CHAIN_LEN = CFG_BITS_PER_PIN * WIDTH;
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);

  logic [CHAIN_LEN-1:0] chain_q, chain_d;
  logic [CHAIN_LEN-1:0] cfg_q, cfg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;

  // Commit looks at the pre-edge chain and count; a simultaneous shift still lands.
  always_comb begin
    chain_d = chain_q;
    cfg_d   = cfg_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (CFG_EN) begin
      chain_d = {chain_q[CHAIN_LEN-2:0], CFG_DIN};
      if (cnt_q != CNT_FULL) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    if (CFG_LOAD) begin
      if (cnt_q == CNT_FULL) begin
        cfg_d = chain_q;
        err_d = 1'b0;
      end else begin
        err_d = 1'b1;
      end
      cnt_d = CFG_EN ? CNT_W'(1) : '0;
    end
  end

  always_ff @(posedge IOCLK or negedge RSTN) begin
    if (!RSTN) begin
      chain_q <= '0;
      cfg_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      chain_q <= chain_d;
      cfg_q   <= cfg_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign CFG_DOUT = chain_q[CHAIN_LEN-1];
  assign CFG_ERR  = err_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    localparam int BASE = CFG_BITS_PER_PIN * i;
    pin_cfg_t pin_cfg;

    assign pin_cfg.tsmux  = tsmux_e'(cfg_q[BASE + TSMUX_LSB +: 2]);
    assign pin_cfg.dorreg = cfg_q[BASE + DORREG_BIT];
    assign pin_cfg.outreg = cfg_q[BASE + OUTREG_BIT];

    ioblock_cell u_cell (
      .clk     (IOCLK),
      .rst_n   (RSTN),
      .ce      (CE),
      .cfg     (pin_cfg),
      .fab_ts  (TS[i]),
      .fab_out (OUT[i]),
      .fab_in  (IN[i]),
      .pin     (PIN[i])
    );
  end

endmodule
